// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared RV32M multiply/divide encodings, FSM states and constants.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    localparam int          ITER_COUNT = 32;
    localparam logic [31:0] DIV0_QUOT  = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the issuing pipeline and muldiv_unit.
interface muldiv_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (output start, op, rs1_data, rs2_data, input busy, done, result);
    modport slave  (input start, op, rs1_data, rs2_data, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per cycle on operand magnitudes,
// with a final sign-fix cycle; divide-by-zero and signed overflow finish immediately.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  io_bus
);

    state_e      r_state, w_next;
    op_e         r_op, w_op;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc, w_acc_next, w_shl, w_prod;
    logic [31:0] r_b, r_result;
    logic        r_neg;

    logic        w_accept, w_sa, w_sb, w_div0, w_ovf, w_special, w_neg;
    logic [31:0] w_mag_a, w_mag_b, w_special_res, w_dv, w_dv_s, w_fix_res;
    logic [32:0] w_sum, w_diff;

    assign w_op     = op_e'(io_bus.op);
    assign w_accept = io_bus.start && (r_state == IDLE || r_state == DONE);
    assign w_sa     = w_op == OP_MULH || w_op == OP_MULHSU || w_op == OP_DIV || w_op == OP_REM;
    assign w_sb     = w_op == OP_MULH || w_op == OP_DIV || w_op == OP_REM;
    assign w_mag_a  = magnitude(io_bus.rs1_data, w_sa);
    assign w_mag_b  = magnitude(io_bus.rs2_data, w_sb);
    assign w_div0   = w_op[2] && io_bus.rs2_data == '0;
    assign w_ovf    = (w_op == OP_DIV || w_op == OP_REM) && io_bus.rs1_data == INT_MIN
                      && io_bus.rs2_data == DIV0_QUOT;
    assign w_special     = w_div0 || w_ovf;
    assign w_special_res = w_div0 ? (w_op[1] ? io_bus.rs1_data : DIV0_QUOT)
                                  : (w_op[1] ? 32'd0 : INT_MIN);
    // Remainder takes the dividend's sign; products and quotients take the xor of both.
    assign w_neg = (w_op[2] && w_op[1]) ? (w_sa && io_bus.rs1_data[31])
                                        : (w_sa && io_bus.rs1_data[31]) ^ (w_sb && io_bus.rs2_data[31]);

    assign w_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    assign w_shl  = {r_acc[62:0], 1'b0};
    // The shifted partial remainder can reach 33 bits, so keep the bit that falls off the top.
    assign w_diff = {r_acc[63], w_shl[63:32]} - {1'b0, r_b};
    assign w_acc_next = !r_op[2] ? {w_sum, r_acc[31:1]}
                      : w_diff[32] ? w_shl : {w_diff[31:0], w_shl[31:1], 1'b1};

    assign w_prod    = r_neg ? -r_acc : r_acc;
    assign w_dv      = r_op[1] ? r_acc[63:32] : r_acc[31:0];
    assign w_dv_s    = r_neg ? -w_dv : w_dv;
    assign w_fix_res = r_op[2] ? w_dv_s : (r_op == OP_MUL ? w_prod[31:0] : w_prod[63:32]);

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        io_bus.busy    = r_state == CALC || r_state == FIX;
        io_bus.done    = r_state == DONE;
        io_bus.result  = r_result;
        case (r_state)
            IDLE, DONE: w_next = w_accept ? (w_special ? DONE : CALC) : IDLE;
            CALC:       w_next = r_cnt == 5'(ITER_COUNT - 1) ? FIX : CALC;
            FIX:        w_next = DONE;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_b      <= '0;
            r_op     <= OP_MUL;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_op  <= w_op;
            r_b   <= w_mag_b;
            r_neg <= w_neg;
            r_acc <= {32'd0, w_mag_a};
            if (w_special) r_result <= w_special_res;
        end else if (r_state == CALC) begin
            r_cnt <= r_cnt + 5'd1;
            r_acc <= w_acc_next;
        end else if (r_state == FIX) begin
            r_result <= w_fix_res;
        end
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; the data width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 start  input  1  request pulse; sampled only when ready to accept (IDLE or DONE).
REQ-005 op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_data  input  32  operand A (register file read port 1).
REQ-007 rs2_data  input  32  operand B (register file read port 2).
REQ-008 busy  output  1  high while an operation is in progress; drives pipeline/PC stall.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 result  output  32  write-back data for the register file write port.

Function
REQ-011 The FSM SHALL have the states IDLE, CALC, FIX and DONE.
REQ-012 When start=1 in IDLE or DONE, the block SHALL capture op, rs1_data and rs2_data, then enter CALC with the iteration counter at 0.
REQ-013 For a normal operation, the block SHALL iterate for exactly 32 cycles in CALC, one bit per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-014 Each iteration SHALL operate on operand magnitudes; signedness SHALL be per op (MULH/DIV/REM both signed, MULHSU A signed and B unsigned, others unsigned).
REQ-015 After counter=31, the block SHALL spend one cycle in FIX to apply sign correction and select the low/high product word, quotient or remainder.
REQ-016 The remainder sign SHALL follow the dividend, and the quotient SHALL truncate toward zero.
REQ-017 After FIX, the block SHALL enter DONE for exactly one cycle with done=1.
REQ-018 For a normal operation, done SHALL be asserted on the 34th rising edge after the edge that sampled start.
REQ-019 busy SHALL be 1 in CALC and FIX and 0 in IDLE and DONE.
REQ-020 done SHALL be 1 only in DONE.
REQ-021 On divide by zero, DIV/DIVU SHALL return 0xFFFFFFFF and REM/REMU SHALL return rs1_data.
REQ-022 On signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF), DIV SHALL return 0x80000000 and REM SHALL return 0.
REQ-023 Both special cases SHALL bypass CALC/FIX and go from the accept state directly to DONE, with done on the next edge.
REQ-024 start in CALC or FIX SHALL be ignored without affecting the operation in progress.
REQ-025 start in DONE SHALL be accepted, giving back-to-back operations with no idle cycle.
REQ-026 Without start, DONE SHALL return to IDLE.
REQ-027 result SHALL hold its last value until the next DONE.
REQ-028 Operand inputs SHALL be ignored after capture and MAY change freely during CALC and FIX.

Reset
REQ-029 With reset=0 at a rising edge, the block SHALL enter IDLE and clear busy, done, result, the counter and internal accumulators, from any state including mid-CALC.
REQ-030 An operation interrupted by reset SHALL be discarded and SHALL NOT produce a done pulse.
REQ-031 When reset=0 and start=1 at the same edge, reset SHALL take priority.

Structure
REQ-032 The shared package muldiv_pkg SHALL hold the op enumeration (funct3 encodings), the FSM state enumeration and the constants ITER_COUNT=32, DIV0_QUOT=0xFFFFFFFF and INT_MIN=0x80000000.
REQ-033 The block SHALL be implemented as a single module with no sub-module.
REQ-034 The block SHALL use one 64-bit shared accumulator for product and remainder/quotient, plus a 5-bit counter.

Verification
REQ-035 MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, done at edge +34, busy high edges +1..+33.
REQ-036 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-037 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-038 DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; all with done at edge +1 and busy never high.
REQ-039 Assert reset=0 at edge +10 of a DIV -> busy=0, done=0, result=0 at the next edge, and no done pulse follows.
REQ-040 Pulse start with new operands at edge +5 of a MUL 3x4 -> ignored, result 12; start in the DONE cycle -> second operation completes 34 edges later.
